// File: rtl/spi_alu_pkg.sv
// Shared types and constants for the SPI-driven ALU slave.
package spi_alu_pkg;

    // Two-bit operation code carried at the head of every frame.
    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } opcode_t;

    // Frame-level controller states.
    typedef enum logic [2:0] {
        IDLE,
        RX,
        EXEC,
        TX,
        HOLD
    } state_t;

    // Flag vector is ordered {N, Z, C, V}, matching the order shifted out on MISO.
    localparam int NUM_FLAGS = 4;
    localparam int FLAG_N    = 3;
    localparam int FLAG_Z    = 2;
    localparam int FLAG_C    = 1;
    localparam int FLAG_V    = 0;

endpackage

// File: rtl/alu_n.sv
// Combinational WIDTH-bit ALU: add, subtract, AND, OR with NZCV flags.
module alu_n
    import spi_alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [WIDTH-1:0]     result,
    output logic [NUM_FLAGS-1:0] flags
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic           carry;
    logic           ovf;

    // Result and flags for the selected operation; subtract carry means "no borrow".
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sum    = {1'b0, a} + {1'b0, b};
        diff   = {1'b0, a} - {1'b0, b};
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (opcode_t'(op))
            OP_ADD: begin
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
                ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                result = diff[WIDTH-1:0];
                carry  = ~diff[WIDTH];
                ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            default: result = '0;
        endcase
        flags         = '0;
        flags[FLAG_N] = result[WIDTH-1];
        flags[FLAG_Z] = (result == '0);
        flags[FLAG_C] = carry;
        flags[FLAG_V] = ovf;
    end

endmodule

// File: rtl/spi_alu_slave.sv
// SPI-framed ALU slave: receives {opcode, A, B}, returns {result, N, Z, C, V},
// and drives a seven-segment display and a PWM output from the last result.
module spi_alu_slave
    import spi_alu_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int PWM_BITS = WIDTH
) (
    input  logic       SLCK,
    input  logic       RST,
    input  logic       CS,
    input  logic       MOSI,
    output logic       MISO,
    output logic [6:0] display,
    output logic       N,
    output logic       Z,
    output logic       C,
    output logic       V,
    output logic       speed,
    output logic       done
);

    localparam int FRAME_BITS = 2 + 2 * WIDTH;
    localparam int TX_BITS    = WIDTH + NUM_FLAGS;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);
    localparam int PWM_SHIFT  = PWM_BITS - WIDTH;
    localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(TX_BITS - 1);

    state_t                  state;
    state_t                  state_next;
    logic                    capture;
    logic                    load;
    logic                    shift_out;
    logic                    finish;
    logic [CNT_W-1:0]        bit_cnt;
    logic [FRAME_BITS-1:0]   rx_shift;
    logic [TX_BITS-1:0]      tx_shift;
    logic [WIDTH-1:0]        result;
    logic [NUM_FLAGS-1:0]    flags;
    logic [WIDTH-1:0]        alu_result;
    logic [NUM_FLAGS-1:0]    alu_flags;
    logic [PWM_BITS-1:0]     pwm_cnt;
    logic [PWM_BITS-1:0]     duty;

    alu_n #(.WIDTH(WIDTH)) u_alu (
        .op     (rx_shift[FRAME_BITS-1 -: 2]),
        .a      (rx_shift[2*WIDTH-1 -: WIDTH]),
        .b      (rx_shift[WIDTH-1:0]),
        .result (alu_result),
        .flags  (alu_flags)
    );

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge SLCK) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    // Next state and per-edge datapath strobes; CS high aborts any active frame.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        load       = 1'b0;
        shift_out  = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: if (!CS) begin
                state_next = RX;
                capture    = 1'b1;
            end
            RX: if (CS) begin
                state_next = IDLE;
            end else begin
                capture = 1'b1;
                if (bit_cnt == RX_LAST) state_next = EXEC;
            end
            EXEC: if (CS) begin
                state_next = IDLE;
            end else begin
                load       = 1'b1;
                state_next = TX;
            end
            TX: if (CS) begin
                state_next = IDLE;
            end else if (bit_cnt == TX_LAST) begin
                finish     = 1'b1;
                state_next = HOLD;
            end else begin
                shift_out = 1'b1;
            end
            HOLD: if (CS) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Frame shifters, result/flag registers and the registered serial outputs.
    always_ff @(posedge SLCK) begin
        if (RST) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
            result   <= '0;
            flags    <= '0;
            MISO     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= finish;
            MISO <= 1'b0;
            if (capture) begin
                rx_shift <= {rx_shift[FRAME_BITS-2:0], MOSI};
                bit_cnt  <= (state == IDLE) ? CNT_W'(1) : bit_cnt + CNT_W'(1);
            end
            if (load) begin
                result   <= alu_result;
                flags    <= alu_flags;
                tx_shift <= {alu_result[WIDTH-2:0], alu_flags, 1'b0};
                MISO     <= alu_result[WIDTH-1];
                bit_cnt  <= '0;
            end
            if (shift_out) begin
                MISO     <= tx_shift[TX_BITS-1];
                tx_shift <= {tx_shift[TX_BITS-2:0], 1'b0};
                bit_cnt  <= bit_cnt + CNT_W'(1);
            end
        end
    end

    // Free-running PWM counter; wraps naturally at all-ones.
    always_ff @(posedge SLCK) begin
        if (RST) pwm_cnt <= '0;
        else     pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end

    assign duty  = PWM_BITS'(result) << PWM_SHIFT;
    assign speed = (pwm_cnt < duty);

    assign N = flags[FLAG_N];
    assign Z = flags[FLAG_Z];
    assign C = flags[FLAG_C];
    assign V = flags[FLAG_V];

    // Hex seven-segment decode of the low result nibble, {g,f,e,d,c,b,a}.
    always_comb begin
        case (result[3:0])
            4'h0: display = 7'b0111111;
            4'h1: display = 7'b0000110;
            4'h2: display = 7'b1011011;
            4'h3: display = 7'b1001111;
            4'h4: display = 7'b1100110;
            4'h5: display = 7'b1101101;
            4'h6: display = 7'b1111101;
            4'h7: display = 7'b0000111;
            4'h8: display = 7'b1111111;
            4'h9: display = 7'b1101111;
            4'hA: display = 7'b1110111;
            4'hB: display = 7'b1111100;
            4'hC: display = 7'b0111001;
            4'hD: display = 7'b1011110;
            4'hE: display = 7'b1111001;
            default: display = 7'b1110001;
        endcase
    end

endmodule
